// File: rtl/wb_stage_if.sv
// MEM-to-WB stage bundle: stage inputs, register-file write port and forwarding copy.
// The HI/LO signals exist only when WB_HILO_EN is defined.
interface wb_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          Stall;
    logic          Flush;
    logic          ValidIn;
    logic          RegWriteIn;
    logic          MemtoReg;
    logic          MULOp;
    logic [2:0]    Memfunc;
    logic [AW-1:0] RAddrIn;
    logic [1:0]    MemAddrLo;
    logic [DW-1:0] ALUData;
    logic [DW-1:0] MemData;
    logic          RegWrite;
    logic [AW-1:0] RegAddr;
    logic [DW-1:0] RData;
    logic          Misalign;
    logic          FwdValid;
    logic [AW-1:0] FwdAddr;
    logic [DW-1:0] FwdData;
`ifdef WB_HILO_EN
    logic [DW-1:0] MulHi;
    logic [DW-1:0] MulLo;
    logic [1:0]    HiLoSel;
    logic [DW-1:0] HiReg;
    logic [DW-1:0] LoReg;
`endif

    // Handshake: none; Stall holds and Flush bubbles the stage register on the rising edge.
    modport master (
`ifdef WB_HILO_EN
        output MulHi, MulLo, HiLoSel,
        input  HiReg, LoReg,
`endif
        output Stall, Flush, ValidIn, RegWriteIn, MemtoReg, MULOp,
        output Memfunc, RAddrIn, MemAddrLo, ALUData, MemData,
        input  RegWrite, RegAddr, RData, Misalign, FwdValid, FwdAddr, FwdData
    );

    modport slave (
`ifdef WB_HILO_EN
        input  MulHi, MulLo, HiLoSel,
        output HiReg, LoReg,
`endif
        input  Stall, Flush, ValidIn, RegWriteIn, MemtoReg, MULOp,
        input  Memfunc, RAddrIn, MemAddrLo, ALUData, MemData,
        output RegWrite, RegAddr, RData, Misalign, FwdValid, FwdAddr, FwdData
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registers MEM results, extracts big-endian load data, drives the GPR
// write port once per instruction and a forwarding copy. Optional HI/LO via WB_HILO_EN.
module wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic     Clock,
    input  logic     Reset,
    wb_stage_if.slave wb
);
    logic          r_valid;
    logic          r_wr;
    logic          r_m2r;
    logic          r_committed;
    logic [2:0]    r_func;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_off;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_mem;
    logic          r_fwd_valid;
    logic [AW-1:0] r_fwd_addr;
    logic [DW-1:0] r_fwd_data;

    logic          w_load;
    logic          w_we;
    logic          w_mis;
    logic          w_is_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_ext;
    logic [DW-1:0] w_data;

`ifdef WB_HILO_EN
    logic          r_mul;
    logic [1:0]    r_sel;
    logic [DW-1:0] r_mulhi;
    logic [DW-1:0] r_mullo;
    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;
`else
    logic          w_unused_mulop;
    assign w_unused_mulop = wb.MULOp;
`endif

    // Flush overrides Stall, so the register takes new contents whenever either allows it.
    assign w_load = wb.Flush | ~wb.Stall;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_valid     <= 1'b0;
            r_wr        <= 1'b0;
            r_m2r       <= 1'b0;
            r_committed <= 1'b0;
            r_func      <= '0;
            r_addr      <= '0;
            r_off       <= '0;
            r_alu       <= '0;
            r_mem       <= '0;
`ifdef WB_HILO_EN
            r_mul       <= 1'b0;
            r_sel       <= '0;
            r_mulhi     <= '0;
            r_mullo     <= '0;
`endif
        end else if (w_load) begin
            r_valid     <= wb.ValidIn & ~wb.Flush;
            r_wr        <= wb.RegWriteIn;
            r_m2r       <= wb.MemtoReg;
            r_committed <= 1'b0;
            r_func      <= wb.Memfunc;
            r_addr      <= wb.RAddrIn;
            r_off       <= wb.MemAddrLo;
            r_alu       <= wb.ALUData;
            r_mem       <= wb.MemData;
`ifdef WB_HILO_EN
            r_mul       <= wb.MULOp;
            r_sel       <= wb.HiLoSel;
            r_mulhi     <= wb.MulHi;
            r_mullo     <= wb.MulLo;
`endif
        end else if (r_valid) begin
            // A held instruction has had its one write cycle; suppress repeats while stalled.
            r_committed <= 1'b1;
        end
    end

    always_comb begin
        w_byte = r_mem[7:0];
        case (r_off)
            2'd0:    w_byte = r_mem[31:24];
            2'd1:    w_byte = r_mem[23:16];
            2'd2:    w_byte = r_mem[15:8];
            default: w_byte = r_mem[7:0];
        endcase
        w_half = r_off[1] ? r_mem[15:0] : r_mem[31:16];
        w_ext  = r_mem;
        case (r_func)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = r_mem;
        endcase
        w_data = r_m2r ? w_ext : r_alu;
`ifdef WB_HILO_EN
        if (r_sel != 2'b00) begin
            w_data = r_sel[1] ? r_hi : r_lo;
        end
`endif
    end

    assign w_is_word = (r_func[1:0] != 2'b00) && (r_func[1:0] != 2'b01);
    assign w_mis     = r_m2r & (((r_func[1:0] == 2'b01) & r_off[0]) |
                                (w_is_word & (r_off != 2'b00)));

`ifdef WB_HILO_EN
    assign w_we = r_valid & r_wr & ~r_committed & (r_addr != '0) & ~r_mul;
`else
    assign w_we = r_valid & r_wr & ~r_committed & (r_addr != '0);
`endif

    assign wb.RegWrite = w_we;
    assign wb.RegAddr  = r_valid ? r_addr : '0;
    assign wb.RData    = r_valid ? w_data : '0;
    assign wb.Misalign = r_valid & w_mis;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else if (w_we) begin
            r_fwd_valid <= 1'b1;
            r_fwd_addr  <= r_addr;
            r_fwd_data  <= w_data;
        end else begin
            r_fwd_valid <= 1'b0;
        end
    end

    assign wb.FwdValid = r_fwd_valid;
    assign wb.FwdAddr  = r_fwd_addr;
    assign wb.FwdData  = r_fwd_data;

`ifdef WB_HILO_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_valid & r_mul & ~r_committed) begin
            r_hi <= r_mulhi;
            r_lo <= r_mullo;
        end
    end

    assign wb.HiReg = r_valid ? r_hi : '0;
    assign wb.LoReg = r_valid ? r_lo : '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed checks of the documented cases, then randomized traffic
// against an instruction-level reference model. Define WB_HILO_EN to cover HI/LO.
module tb_wb_stage;
  logic Clock = 1'b0;
  logic Reset;
  wb_stage_if bus ();
  wb_stage dut (.Clock(Clock), .Reset(Reset), .wb(bus));

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // Reference model: the instruction currently presented and whether it has written.
  bit          m_v, m_wr, m_m2r, m_done, m_mul, m_fv;
  int          m_func, m_addr, m_off, m_sel, m_fa;
  logic [31:0] m_alu, m_mem, m_mh, m_ml, m_hi, m_lo, m_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_we();
    bit we;
    we = m_v && m_wr && !m_done && (m_addr != 0);
`ifdef WB_HILO_EN
    we = we && !m_mul;
`endif
    return we;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] b, h;
    if (!m_v) return 32'd0;
`ifdef WB_HILO_EN
    if (m_sel == 2) return m_hi;
    if (m_sel == 3) return m_hi;
    if (m_sel == 1) return m_lo;
`endif
    if (!m_m2r) return m_alu;
    b = (m_mem >> (8 * (3 - m_off))) & 32'hFF;
    h = (m_mem >> ((m_off >= 2) ? 0 : 16)) & 32'hFFFF;
    case (m_func)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return m_mem;
    endcase
  endfunction

  function automatic bit exp_mis();
    if (!m_v || !m_m2r) return 1'b0;
    if (m_func == 1 || m_func == 5) return (m_off % 2) == 1;
    if (m_func == 0 || m_func == 4) return 1'b0;
    return m_off != 0;
  endfunction

  task automatic model_reset();
    m_v = 0; m_wr = 0; m_m2r = 0; m_done = 0; m_mul = 0; m_fv = 0;
    m_func = 0; m_addr = 0; m_off = 0; m_sel = 0; m_fa = 0;
    m_alu = 0; m_mem = 0; m_mh = 0; m_ml = 0; m_hi = 0; m_lo = 0; m_fd = 0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit we;
    logic [31:0] d;
    we = exp_we();
    d = exp_data();
    if (we) begin
      m_fv = 1; m_fa = m_addr; m_fd = d;
      exp_q.push_back(d);
    end else begin
      m_fv = 0;
    end
`ifdef WB_HILO_EN
    if (m_v && m_mul && !m_done) begin
      m_hi = m_mh; m_lo = m_ml;
    end
`endif
    if (bus.Flush || !bus.Stall) begin
      m_v = bus.ValidIn && !bus.Flush;
      m_wr = bus.RegWriteIn; m_m2r = bus.MemtoReg; m_mul = bus.MULOp;
      m_func = int'(bus.Memfunc); m_addr = int'(bus.RAddrIn); m_off = int'(bus.MemAddrLo);
      m_alu = bus.ALUData; m_mem = bus.MemData;
`ifdef WB_HILO_EN
      m_sel = int'(bus.HiLoSel); m_mh = bus.MulHi; m_ml = bus.MulLo;
`endif
      m_done = 0;
    end else if (m_v) begin
      m_done = 1;
    end
  endtask

  task automatic check_all();
    chk("reg_write", {31'd0, bus.RegWrite}, {31'd0, exp_we()});
    chk("reg_addr", {27'd0, bus.RegAddr}, m_v ? m_addr : 0);
    chk("rdata", bus.RData, exp_data());
    chk("misalign", {31'd0, bus.Misalign}, {31'd0, exp_mis()});
    chk("fwd_valid", {31'd0, bus.FwdValid}, {31'd0, m_fv});
    chk("fwd_addr", {27'd0, bus.FwdAddr}, m_fa);
    if (m_fv && exp_q.size() != 0) chk("fwd_data_q", bus.FwdData, exp_q.pop_front());
    else chk("fwd_data", bus.FwdData, m_fd);
`ifdef WB_HILO_EN
    chk("hi_reg", bus.HiReg, m_v ? m_hi : 32'd0);
    chk("lo_reg", bus.LoReg, m_v ? m_lo : 32'd0);
`endif
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic drive_instr(input bit v, input bit wr, input bit m2r, input int func,
                             input int addr, input int off, input logic [31:0] alu,
                             input logic [31:0] mem);
    bus.ValidIn = v; bus.RegWriteIn = wr; bus.MemtoReg = m2r;
    bus.Memfunc = func[2:0]; bus.RAddrIn = addr[4:0]; bus.MemAddrLo = off[1:0];
    bus.ALUData = alu; bus.MemData = mem; bus.MULOp = 1'b0;
`ifdef WB_HILO_EN
    bus.HiLoSel = 2'b00; bus.MulHi = 32'd0; bus.MulLo = 32'd0;
`endif
  endtask

  task automatic drive_idle();
    drive_instr(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
  endtask

  int ld_func[5] = '{0, 4, 1, 5, 1};
  int ld_off[5]  = '{1, 0, 2, 0, 1};
  logic [31:0] ld_exp[5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01,
                             32'h0000_80FF, 32'hFFFF_80FF};
  bit ld_mis[5] = '{0, 0, 0, 0, 1};

  initial begin
    int wr_cnt;
    Reset = 1'b1;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    drive_idle();
    model_reset();
    #2;
    check_all();
    @(posedge Clock);
    #3;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    check_all();

    // ALU write to r5 and its forwarding copy one cycle later
    drive_instr(1, 1, 0, 3, 5, 0, 32'h1234_5678, 32'd0);
    cycle();
    chk("t1_we", {31'd0, bus.RegWrite}, 32'd1);
    chk("t1_addr", {27'd0, bus.RegAddr}, 32'd5);
    chk("t1_data", bus.RData, 32'h1234_5678);
    drive_idle();
    cycle();
    chk("t1_fwd_valid", {31'd0, bus.FwdValid}, 32'd1);
    chk("t1_fwd_data", bus.FwdData, 32'h1234_5678);

    // Big-endian load extraction
    for (int i = 0; i < 5; i++) begin
      drive_instr(1, 1, 1, ld_func[i], 3, ld_off[i], 32'hDEAD_BEEF, 32'h80FF_7F01);
      cycle();
      chk($sformatf("t2_load%0d_data", i), bus.RData, ld_exp[i]);
      chk($sformatf("t2_load%0d_mis", i), {31'd0, bus.Misalign}, {31'd0, ld_mis[i]});
    end

    // Writes to $0 are never issued
    drive_instr(1, 1, 0, 3, 0, 0, 32'h0000_00AA, 32'd0);
    cycle();
    chk("t3_we", {31'd0, bus.RegWrite}, 32'd0);
    drive_idle();
    cycle();
    chk("t3_fwd_valid", {31'd0, bus.FwdValid}, 32'd0);

    // Three-cycle stall on r7: one write only, then the next instruction enters
    drive_instr(1, 1, 0, 3, 7, 0, 32'h0000_0777, 32'd0);
    cycle();
    wr_cnt = int'(bus.RegWrite);
    bus.Stall = 1'b1;
    drive_instr(1, 1, 0, 3, 8, 0, 32'h0000_0888, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      wr_cnt += int'(bus.RegWrite);
      chk("t4_hold_addr", {27'd0, bus.RegAddr}, 32'd7);
    end
    chk("t4_write_count", wr_cnt, 32'd1);
    bus.Stall = 1'b0;
    cycle();
    chk("t4_new_addr", {27'd0, bus.RegAddr}, 32'd8);
    chk("t4_new_we", {31'd0, bus.RegWrite}, 32'd1);

    // Flush beats Stall
    drive_instr(1, 1, 0, 3, 10, 0, 32'h0000_0A0A, 32'd0);
    cycle();
    bus.Stall = 1'b1;
    bus.Flush = 1'b1;
    cycle();
    chk("t5_flush_we", {31'd0, bus.RegWrite}, 32'd0);
    chk("t5_flush_data", bus.RData, 32'd0);

    // Reset asserted mid-stall on a held write
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    drive_instr(1, 1, 0, 3, 11, 0, 32'h0000_0B0B, 32'd0);
    cycle();
    bus.Stall = 1'b1;
    cycle();
    Reset = 1'b1;
    #1;
    chk("t5_rst_we", {31'd0, bus.RegWrite}, 32'd0);
    chk("t5_rst_addr", {27'd0, bus.RegAddr}, 32'd0);
    chk("t5_rst_data", bus.RData, 32'd0);
    chk("t5_rst_fwd", {31'd0, bus.FwdValid}, 32'd0);
    model_reset();
    #1;
    Reset = 1'b0;
    cycle();
    bus.Stall = 1'b0;
    drive_idle();
    cycle();
    chk("t5_after_rst_we", {31'd0, bus.RegWrite}, 32'd0);

`ifdef WB_HILO_EN
    // MULT then MFHI into r9
    drive_instr(1, 1, 0, 3, 3, 0, 32'd0, 32'd0);
    bus.MULOp = 1'b1; bus.MulHi = 32'd1; bus.MulLo = 32'd2;
    cycle();
    chk("t6_mul_we", {31'd0, bus.RegWrite}, 32'd0);
    drive_instr(1, 1, 0, 3, 9, 0, 32'h5555_5555, 32'd0);
    bus.HiLoSel = 2'b10;
    cycle();
    chk("t6_hi", bus.HiReg, 32'd1);
    chk("t6_lo", bus.LoReg, 32'd2);
    chk("t6_mfhi_data", bus.RData, 32'd1);
    chk("t6_mfhi_we", {31'd0, bus.RegWrite}, 32'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      bus.Stall = ($urandom_range(0, 3) == 0);
      bus.Flush = ($urandom_range(0, 9) == 0);
      drive_instr($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
                  $urandom_range(0, 3), $urandom, $urandom);
      bus.MULOp = ($urandom_range(0, 5) == 0);
`ifdef WB_HILO_EN
      bus.HiLoSel = 2'($urandom_range(0, 3));
      bus.MulHi = $urandom;
      bus.MulLo = $urandom;
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
